// File: rtl/gsensor_tilt_conditioner.sv
// -----------------------------------------------------------------------------
// gsensor_tilt_conditioner
//
// Purpose:
//   Turns raw accelerometer samples into the tilt_amount/tilt_direction pairs
//   consumed by the G-sensor mark drawer. A free-running period counter
//   schedules one sample request per period. Accepted samples are summed per
//   axis. Every 2^AVG_LOG2 samples, the sums are averaged and passed through a
//   deadzone. The result is scaled and saturated to a 4-bit magnitude plus a
//   sign bit. Both axes are published together with a one-cycle strobe.
//
// Ports:
//   clk               system clock
//   resetN            asynchronous, active-low reset
//   sample_req        one-cycle request pulse to the SPI sensor reader
//   sample_valid      sample_x/sample_y carry a sample this cycle
//   sample_x/y        signed raw acceleration, 16 bits
//   tilt_amount_x/y   published magnitude, 0..15
//   tilt_direction_x/y 0 = positive, 1 = negative
//   tilt_update       one-cycle pulse on every publish
//   timeout_count     saturating count of requests that went unanswered
// -----------------------------------------------------------------------------
module gsensor_tilt_conditioner #(
    parameter int SAMPLE_PERIOD_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES       = 1000,
    parameter int AVG_LOG2             = 3,
    parameter int DEADZONE             = 16,
    parameter int SHIFT                = 4
) (
    input  logic               clk,
    input  logic               resetN,
    output logic               sample_req,
    input  logic               sample_valid,
    input  logic signed [15:0] sample_x,
    input  logic signed [15:0] sample_y,
    output logic [3:0]         tilt_amount_x,
    output logic               tilt_direction_x,
    output logic [3:0]         tilt_amount_y,
    output logic               tilt_direction_y,
    output logic               tilt_update,
    output logic [7:0]         timeout_count
);

    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int PER_W = (SAMPLE_PERIOD_CYCLES > 1) ? $clog2(SAMPLE_PERIOD_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CNT_W = AVG_LOG2 + 1;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [ACC_W-1:0] MAG_MAX  = ACC_W'(32767);
    localparam logic [ACC_W-1:0] DZ       = ACC_W'(DEADZONE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_DATA = 2'd2,
        PUBLISH   = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [PER_W-1:0]          period_q, period_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_x_q, acc_x_d;
    logic signed [ACC_W-1:0]   acc_y_q, acc_y_d;
    logic [3:0]                tilt_amount_x_q, tilt_amount_x_d;
    logic                      tilt_direction_x_q, tilt_direction_x_d;
    logic [3:0]                tilt_amount_y_q, tilt_amount_y_d;
    logic                      tilt_direction_y_q, tilt_direction_y_d;
    logic                      tilt_update_q, tilt_update_d;
    logic [7:0]                timeout_count_q, timeout_count_d;
    logic                      tick;
    logic [4:0]                pub_x, pub_y;

    // Average, deadzone, scale and saturate one axis. Returns {direction, amount}.
    // The average of 16-bit samples always fits 16 bits, so working at ACC_W
    // only matters for the single case avg = -32768, whose magnitude is clamped.
    function automatic logic [4:0] tilt_of(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] avg;
        logic [ACC_W-1:0]        mag;
        logic [ACC_W-1:0]        scaled;
        avg = acc >>> AVG_LOG2;
        mag = avg[ACC_W-1] ? -avg : avg;
        if (mag > MAG_MAX) begin
            mag = MAG_MAX;
        end
        if (mag < DZ) begin
            return 5'd0;
        end
        scaled = (mag - DZ) >> SHIFT;
        return {avg[ACC_W-1], (scaled > ACC_W'(15)) ? 4'hf : scaled[3:0]};
    endfunction

    assign tick  = (period_q == PER_LAST);
    assign pub_x = tilt_of(acc_x_q);
    assign pub_y = tilt_of(acc_y_q);

    always_comb begin
        state_d            = state_q;
        period_d           = tick ? '0 : period_q + PER_W'(1);
        tmo_d              = tmo_q;
        cnt_d              = cnt_q;
        acc_x_d            = acc_x_q;
        acc_y_d            = acc_y_q;
        tilt_amount_x_d    = tilt_amount_x_q;
        tilt_direction_x_d = tilt_direction_x_q;
        tilt_amount_y_d    = tilt_amount_y_q;
        tilt_direction_y_d = tilt_direction_y_q;
        tilt_update_d      = 1'b0;
        timeout_count_d    = timeout_count_q;
        sample_req         = 1'b0;

        unique case (state_q)
            // Ticks seen in any other state are simply lost.
            IDLE: begin
                if (tick) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                sample_req = 1'b1;
                tmo_d      = '0;
                state_d    = WAIT_DATA;
            end
            // A sample arriving on the expiry cycle wins over the timeout.
            WAIT_DATA: begin
                if (sample_valid) begin
                    acc_x_d = acc_x_q + $signed({{AVG_LOG2{sample_x[15]}}, sample_x});
                    acc_y_d = acc_y_q + $signed({{AVG_LOG2{sample_y[15]}}, sample_y});
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == CNT_LAST) ? PUBLISH : IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    // Partial sums are kept; the next tick retries.
                    if (timeout_count_q != 8'hff) begin
                        timeout_count_d = timeout_count_q + 8'd1;
                    end
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            PUBLISH: begin
                {tilt_direction_x_d, tilt_amount_x_d} = pub_x;
                {tilt_direction_y_d, tilt_amount_y_d} = pub_y;
                tilt_update_d = 1'b1;
                acc_x_d       = '0;
                acc_y_d       = '0;
                cnt_d         = '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q            <= IDLE;
            period_q           <= '0;
            tmo_q              <= '0;
            cnt_q              <= '0;
            acc_x_q            <= '0;
            acc_y_q            <= '0;
            tilt_amount_x_q    <= '0;
            tilt_direction_x_q <= 1'b0;
            tilt_amount_y_q    <= '0;
            tilt_direction_y_q <= 1'b0;
            tilt_update_q      <= 1'b0;
            timeout_count_q    <= '0;
        end else begin
            state_q            <= state_d;
            period_q           <= period_d;
            tmo_q              <= tmo_d;
            cnt_q              <= cnt_d;
            acc_x_q            <= acc_x_d;
            acc_y_q            <= acc_y_d;
            tilt_amount_x_q    <= tilt_amount_x_d;
            tilt_direction_x_q <= tilt_direction_x_d;
            tilt_amount_y_q    <= tilt_amount_y_d;
            tilt_direction_y_q <= tilt_direction_y_d;
            tilt_update_q      <= tilt_update_d;
            timeout_count_q    <= timeout_count_d;
        end
    end

    assign tilt_amount_x    = tilt_amount_x_q;
    assign tilt_direction_x = tilt_direction_x_q;
    assign tilt_amount_y    = tilt_amount_y_q;
    assign tilt_direction_y = tilt_direction_y_q;
    assign tilt_update      = tilt_update_q;
    assign timeout_count    = timeout_count_q;

endmodule

// File: tb/tb_gsensor_tilt_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gsensor_tilt_conditioner
//
// Bench for gsensor_tilt_conditioner with a short sample period. A reader
// model answers each sample_req two cycles later. It can also withhold an
// answer, or answer on the timeout-expiry cycle. A reference model sums the
// delivered samples, derives each expected publish with integer division, and
// predicts the cycle of every tilt_update and every timeout_count step.
// -----------------------------------------------------------------------------
module tb_gsensor_tilt_conditioner;

    localparam int PERIOD   = 20;
    localparam int TMO      = 8;
    localparam int AVG_LOG2 = 3;
    localparam int DEADZONE = 16;
    localparam int SHIFT    = 4;
    localparam int AVG_N    = 1 << AVG_LOG2;
    localparam int STEP     = 1 << SHIFT;

    logic               clk;
    logic               resetN;
    logic               sample_req;
    logic               sample_valid;
    logic signed [15:0] sample_x;
    logic signed [15:0] sample_y;
    logic [3:0]         tilt_amount_x;
    logic               tilt_direction_x;
    logic [3:0]         tilt_amount_y;
    logic               tilt_direction_y;
    logic               tilt_update;
    logic [7:0]         timeout_count;

    gsensor_tilt_conditioner #(
        .SAMPLE_PERIOD_CYCLES(PERIOD),
        .TIMEOUT_CYCLES      (TMO),
        .AVG_LOG2            (AVG_LOG2),
        .DEADZONE            (DEADZONE),
        .SHIFT               (SHIFT)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .sample_req      (sample_req),
        .sample_valid    (sample_valid),
        .sample_x        (sample_x),
        .sample_y        (sample_y),
        .tilt_amount_x   (tilt_amount_x),
        .tilt_direction_x(tilt_direction_x),
        .tilt_amount_y   (tilt_amount_y),
        .tilt_direction_y(tilt_direction_y),
        .tilt_update     (tilt_update),
        .timeout_count   (timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         sx_q[$];
    int         sy_q[$];
    int         exp_cyc_q[$];
    logic [9:0] exp_val_q[$];
    logic [9:0] cur_exp  = '0;
    int         exp_to   = 0;
    int         due      = 0;
    int         to_due   = 0;
    int         m_sum_x  = 0;
    int         m_sum_y  = 0;
    int         m_n      = 0;
    int         n_reqs   = 0;
    int         last_req = 0;
    bit         have_last_req = 0;
    int         n_updates = 0;
    int         reqs_at_update = 0;
    int         withhold_at = -1;
    int         late_at = -1;
    bit         rand_withhold = 0;
    bit         spur = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected {direction, amount} for one axis from the sum of AVG_N samples.
    function automatic logic [4:0] ref_axis(input int sum);
        int avg, mag, amt;
        avg = (sum >= 0) ? sum / AVG_N : -((-sum + AVG_N - 1) / AVG_N);
        mag = (avg < 0) ? -avg : avg;
        if (mag > 32767) mag = 32767;
        if (mag < DEADZONE) return 5'd0;
        amt = (mag - DEADZONE) / STEP;
        if (amt > 15) amt = 15;
        return {(avg < 0) ? 1'b1 : 1'b0, amt[3:0]};
    endfunction

    // Monitor, reference model and sensor reader, all on the falling edge.
    initial begin
        sample_valid = 1'b0;
        sample_x = '0;
        sample_y = '0;
        forever begin
            @(negedge clk);
            cyc++;
            sample_valid = 1'b0;
            if (!resetN) begin
                due = 0; to_due = 0; m_sum_x = 0; m_sum_y = 0; m_n = 0;
                exp_cyc_q.delete(); exp_val_q.delete();
                cur_exp = '0; exp_to = 0; have_last_req = 0; spur = 0;
                chk("reset_tilt", {tilt_direction_x, tilt_amount_x, tilt_direction_y, tilt_amount_y}, 0);
                chk("reset_timeouts", timeout_count, 0);
                chk("reset_strobes", {sample_req, tilt_update}, 0);
            end else begin
                bit upd_exp;
                if (to_due > 0) begin
                    to_due--;
                    if (to_due == 0 && exp_to < 255) exp_to++;
                end
                upd_exp = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
                if (upd_exp) begin
                    cur_exp = exp_val_q.pop_front();
                    void'(exp_cyc_q.pop_front());
                end
                chk("tilt_update", tilt_update, upd_exp);
                chk("tilt_outputs", {tilt_direction_x, tilt_amount_x, tilt_direction_y, tilt_amount_y}, cur_exp);
                chk("timeout_count", timeout_count, exp_to);
                if (tilt_update) begin
                    n_updates++;
                    reqs_at_update = n_reqs;
                end
                if (sample_req) begin
                    n_reqs++;
                    if (have_last_req) chk("req_spacing", cyc - last_req, PERIOD);
                    last_req = cyc;
                    have_last_req = 1;
                end

                if (due > 0) begin
                    due--;
                    if (due == 0) begin
                        int vx, vy;
                        vx = (sx_q.size() > 0) ? sx_q.pop_front() : 0;
                        vy = (sy_q.size() > 0) ? sy_q.pop_front() : 0;
                        sample_valid = 1'b1;
                        sample_x = vx[15:0];
                        sample_y = vy[15:0];
                        m_sum_x += vx;
                        m_sum_y += vy;
                        m_n++;
                        if (m_n == AVG_N) begin
                            exp_cyc_q.push_back(cyc + 2);
                            exp_val_q.push_back({ref_axis(m_sum_x), ref_axis(m_sum_y)});
                            m_sum_x = 0; m_sum_y = 0; m_n = 0;
                        end
                    end
                end else if (spur) begin
                    sample_valid = 1'b1;
                    sample_x = 16'sd30000;
                    sample_y = 16'sd30000;
                    spur = 0;
                end

                if (sample_req) begin
                    if (n_reqs == withhold_at || (rand_withhold && $urandom_range(0, 7) == 0))
                        to_due = TMO + 1;
                    else if (n_reqs == late_at)
                        due = TMO;
                    else
                        due = 2;
                end
            end
        end
    end

    task automatic push_const(input int x, input int y, input int n);
        for (int i = 0; i < n; i++) begin
            sx_q.push_back(x);
            sy_q.push_back(y);
        end
    endtask

    task automatic wait_update(input string tag, input int budget);
        int start, k;
        start = n_updates;
        k = 0;
        while (n_updates == start && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_arrived"}, n_updates != start, 1);
    endtask

    task automatic wait_model_n(input int n, input int budget);
        int k;
        k = 0;
        while (m_n < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("model_samples_reached", m_n >= n, 1);
    endtask

    task automatic chk_tilt(input string tag, input int ax, input int dx, input int ay, input int dy);
        chk({tag, "_amount_x"}, tilt_amount_x, ax);
        chk({tag, "_dir_x"}, tilt_direction_x, dx);
        chk({tag, "_amount_y"}, tilt_amount_y, ay);
        chk({tag, "_dir_y"}, tilt_direction_y, dy);
    endtask

    initial begin
        int base;
        resetN = 1'b1;
        #1 resetN = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        #2 resetN = 1'b1;

        // Steady tilt, both signs.
        base = n_reqs;
        push_const(200, -40, 8);
        wait_update("p1", 260);
        chk("p1_requests", reqs_at_update - base, 8);
        chk_tilt("p1", 11, 0, 1, 1);

        // Saturation, including the most negative sample.
        push_const(-1000, 10, 8);
        wait_update("p2", 260);
        chk_tilt("p2", 15, 1, 0, 0);
        push_const(-32768, 0, 8);
        wait_update("p2b", 260);
        chk_tilt("p2b", 15, 1, 0, 0);

        // Cancelling samples, then a small negative inside the deadzone.
        for (int i = 0; i < 8; i++) push_const((i % 2) ? -100 : 100, 0, 1);
        wait_update("p3", 260);
        chk_tilt("p3", 0, 0, 0, 0);
        push_const(-3, 0, 8);
        wait_update("p3b", 260);
        chk_tilt("p3b", 0, 0, 0, 0);

        // Withheld 4th answer: one timeout, publish on the 9th request.
        base = n_reqs;
        withhold_at = n_reqs + 4;
        push_const(200, -40, 8);
        wait_update("p4", 320);
        withhold_at = -1;
        chk("p4_requests", reqs_at_update - base, 9);
        chk("p4_timeouts", timeout_count, 1);
        chk_tilt("p4", 11, 0, 1, 1);

        // Answer lands on the expiry cycle: accepted, no timeout.
        base = n_reqs;
        late_at = n_reqs + 2;
        push_const(40, -200, 8);
        wait_update("p4b", 320);
        late_at = -1;
        chk("p4b_requests", reqs_at_update - base, 8);
        chk("p4b_timeouts", timeout_count, 1);
        chk_tilt("p4b", 1, 0, 11, 1);

        // Reset in the middle of an average.
        push_const(200, 0, 8);
        wait_model_n(5, 200);
        repeat (3) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        chk_tilt("p5_reset", 0, 0, 0, 0);
        chk("p5_reset_timeouts", timeout_count, 0);
        chk("p5_reset_update", tilt_update, 0);
        sx_q.delete();
        sy_q.delete();
        repeat (3) @(negedge clk);
        #2 resetN = 1'b1;
        push_const(40, 0, 8);
        wait_update("p5", 260);
        chk_tilt("p5", 1, 0, 0, 0);

        // Spurious sample_valid while idle must not be accumulated.
        push_const(200, -40, 8);
        wait_model_n(3, 200);
        repeat (3) @(negedge clk);
        spur = 1;
        wait_update("p6", 260);
        chk_tilt("p6", 11, 0, 1, 1);

        // Random batches with occasional missed answers.
        rand_withhold = 1;
        for (int b = 0; b < 8; b++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 8; i++) begin
                logic signed [15:0] r16;
                int v;
                r16 = 16'($urandom);
                case (mode)
                    0: v = r16;
                    1: v = int'($urandom_range(0, 80)) - 40;
                    default: v = int'($urandom_range(0, 1200)) - 600;
                endcase
                sx_q.push_back(v);
                r16 = 16'($urandom);
                sy_q.push_back((mode == 0) ? int'(r16) : int'($urandom_range(0, 500)) - 250);
            end
            wait_update("rand", 700);
        end
        rand_withhold = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected finish", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
